div_iter: RTL
=============

Name: div_iter

Overview:
Iterative radix-2 restoring divider. It is the responder side of the EX-stage divide handshake (start/ready), and serves DIV and DIVU. It accepts a start request with two operands and a signedness flag, runs one quotient bit per cycle, then presents {remainder, quotient} for the HI/LO write. The EX stage stalls the pipeline while ready_o is low.

Parameters:
DATA_W, 32, operand width; result width is 2*DATA_W.

Ports:
clk  input  1  clock, rising edge.
resetn  input  1  asynchronous active-low reset.
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled when a start is accepted.
opdata1_i  input  DATA_W  dividend; sampled when a start is accepted.
opdata2_i  input  DATA_W  divisor; sampled when a start is accepted.
start_i  input  1  request; requester holds it high until it sees ready_o, then drops it.
annul_i  input  1  abort current or pending operation.
result_o  output  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}; registered.
ready_o  output  1  result valid; registered.

Behaviour:
- Reset (resetn=0, async): state=FREE, ready_o=0, result_o=0, counter=0, operand regs=0. A reset mid-operation discards the operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On this transition:
    - latch signed_div_i and the raw operand signs;
    - latch |opdata1_i| and |opdata2_i| when signed, raw values otherwise;
    - clear the partial remainder and set counter=0.
  - Otherwise stay in FREE. ready_o=0 and result_o=0 throughout.
- BYZERO: unconditionally -> END next edge, with result_o=0 (quotient=0, remainder=0).
- ON:
  - annul_i=1 -> FREE immediately on that edge; ready_o stays 0.
  - Otherwise each edge performs one step:
    - shift {rem, dividend} left by 1;
    - if rem >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0;
    - counter++.
  - After exactly DATA_W steps (counter reaches DATA_W) -> END. On that edge load result_o with sign correction:
    - quotient negated if signed and sign(op1)^sign(op2);
    - remainder negated if signed and sign(op1)=1.
  - All arithmetic is modulo 2^DATA_W. The signed case 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no error.
- END:
  - ready_o=1; result_o held stable.
  - start_i=0 -> FREE next edge, clearing ready_o and result_o to 0.
  - start_i=1 -> stay in END (no restart until start_i drops).
  - annul_i=1 -> FREE, outputs cleared.
- Latency:
  - Normal divide: ready_o is first seen high after exactly DATA_W+1 edges counted from the edge that accepts start (33 edges for DATA_W=32).
  - Divide by zero: ready_o high after 2 edges.
- Operand inputs are ignored outside the accepting edge; changes during ON do not affect the result.
- annul_i together with start_i in FREE: annul wins, stay in FREE.
- ready_o is never high in FREE, BYZERO or ON. result_o is nonzero only in END.

Test Plan:
- Unsigned 100/7: opdata1=0x00000064, opdata2=0x00000007, signed=0, start held.
  -> ready_o rises at edge 33; result_o=0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=0x00000002, signed=1.
  -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3) at edge 33.
- Signed 7/-2 and unsigned 0xFFFFFFFF/1.
  -> 7/-2: result_o=0x00000001_FFFFFFFD.
  -> 0xFFFFFFFF/1: result_o=0x00000000_FFFFFFFF.
  -> Signed 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000.
- Divide by zero: opdata2=0, start=1.
  -> ready_o=1 at edge 2 with result_o=0; held while start=1; cleared one edge after start drops.
- Annul and reset: start 100/7, assert annul_i at step 10.
  -> FREE, ready_o never rises; a new start 9/3 then gives result_o=0x00000000_00000003 at edge 33.
  -> Repeat with resetn pulsed low at step 20: outputs zero immediately (async), state FREE.
- Operand change: after start is accepted for 100/7, change opdata1/opdata2 to 1/1 during ON.
  -> result_o still 0x00000002_0000000E.

Source files
------------

// File: rtl/div_iter_if.sv
// EX-stage divide handshake between the pipeline (master) and the iterative divider (slave).
// Signal suffixes are from the divider's point of view.
interface div_iter_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result presented as {remainder, quotient} for the HI/LO write.
module div_iter #(
    parameter int unsigned DATA_W = 32
) (
    input logic       clk,
    input logic       resetn,
    div_iter_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

    localparam logic [1:0] StFree   = 2'd0;
    localparam logic [1:0] StByZero = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StEnd    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     trial, diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_step, quo_step;

    // Magnitudes are taken modulo 2^DATA_W, so the most negative value maps onto itself.
    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        abs1    = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
        abs2    = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    end

    // The shifted partial remainder needs one extra bit; a clear top bit of the
    // difference means no borrow, i.e. trial >= divisor.
    always_comb begin
        trial    = {rem_q, dvd_q[DATA_W-1]};
        diff     = trial - {1'b0, dvs_q};
        q_bit    = ~diff[DATA_W];
        rem_step = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_step = {dvd_q[DATA_W-2:0], q_bit};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            StFree: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = StByZero;
                    end else begin
                        state_d   = StOn;
                        cnt_d     = '0;
                        rem_d     = '0;
                        dvd_d     = abs1;
                        dvs_d     = abs2;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end
            StByZero: begin
                state_d  = StEnd;
                ready_d  = 1'b1;
                result_d = '0;
            end
            StOn: begin
                if (bus.annul_i) begin
                    state_d = StFree;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    // Final step: sign-correct straight from the last step's values.
                    if (cnt_q == LastCnt) begin
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = {neg_rem_q ? -rem_step : rem_step,
                                    neg_quo_q ? -quo_step : quo_step};
                    end
                end
            end
            StEnd: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = StFree;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
